// File: rtl/axis_vc_link_mux.sv
// Merges NUM_CH AXI-Stream virtual channels onto one link: per-channel FIFOs, packet-atomic round-robin.
// Latency: beat captured at edge N is on the link after edge N+1; backpressure via per-FIFO ready (not full).
module axis_vc_link_mux #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3,
  parameter int DEPTH      = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              s_tvalid,
  output logic [NUM_CH-1:0]              s_tready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_CH*ID_WIDTH-1:0]     s_tid,
  input  logic [NUM_CH-1:0]              s_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic [ID_WIDTH-1:0]            m_tid,
  output logic                           m_tlast,
  output logic [CH_W-1:0]                m_tchan,
  output logic [NUM_CH*CW-1:0]           fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + ID_WIDTH + 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]   empty;
  logic [NUM_CH-1:0]   wr_en;
  logic [NUM_CH-1:0]   rd_en;
  logic [NUM_CH*EW-1:0] head_all;
  logic [EW-1:0]       head;
  logic                grant_empty;
  logic                pop;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [EW-1:0] mem_q [DEPTH];

    // Ready comes only from the registered count, so a full FIFO refuses even while being read.
    assign s_tready[c] = (cnt_q < CW'(DEPTH));
    assign empty[c]    = (cnt_q == '0);
    assign wr_en[c]    = s_tvalid[c] && s_tready[c];
    assign rd_en[c]    = pop && (grant_q == CH_W'(c));
    assign head_all[c*EW +: EW]   = mem_q[rptr_q];
    assign fifo_count[c*CW +: CW] = cnt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_en[c]) wptr_q <= wptr_q + 1'b1;
        if (rd_en[c]) rptr_q <= rptr_q + 1'b1;
        case ({wr_en[c], rd_en[c]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en[c]) begin
        mem_q[wptr_q] <= {s_tlast[c], s_tid[c*ID_WIDTH +: ID_WIDTH],
                          s_tdata[c*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  always_comb begin
    head        = '0;
    grant_empty = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_q == CH_W'(c)) begin
        head        = head_all[c*EW +: EW];
        grant_empty = empty[c];
      end
    end
  end

  assign m_tvalid = (state_q == SEND) && !grant_empty;
  assign pop      = m_tvalid && m_tready;
  assign m_tdata  = head[DATA_WIDTH-1:0];
  assign m_tid    = head[DATA_WIDTH +: ID_WIDTH];
  assign m_tlast  = head[EW-1];
  assign m_tchan  = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        // Search rr_ptr, rr_ptr+1, ... and take the first non-empty channel.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (c == ((int'(rr_ptr_q) + i) % NUM_CH) && !empty[c]) begin
              grant_d = CH_W'(c);
              state_d = SEND;
            end
          end
        end
      end
      SEND: begin
        if (pop && m_tlast) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_vc_link_mux.sv
// Directed bench for axis_vc_link_mux with 4 channels, DEPTH 4; channel c carries tdata {16'h0, c, dat}.
module tb_axis_vc_link_mux;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int IW  = 3;
  localparam int CW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH-1:0]    s_tready;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH*IW-1:0] s_tid;
  logic [NCH-1:0]    s_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic [IW-1:0]     m_tid;
  logic              m_tlast;
  logic [1:0]        m_tchan;
  logic [NCH*CW-1:0] fifo_count;

  int n_chk = 0;
  int n_err = 0;

  axis_vc_link_mux #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tid(s_tid), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tid(m_tid), .m_tlast(m_tlast),
    .m_tchan(m_tchan), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [7:0]  dat;
    logic        rdy;
    logic        e_vld;
    logic [1:0]  e_chan;
    logic [15:0] e_dat;
    logic        e_last;
    logic [3:0]  e_srdy;
    logic [2:0]  e_cnt0;
    logic [2:0]  e_cnt1;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge take them, then sample 1 time unit later.
  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic [7:0] d, input logic rdy);
    rst      = r;
    s_tvalid = v;
    s_tlast  = l;
    m_tready = rdy;
    for (int c = 0; c < NCH; c++) begin
      s_tdata[c*DW +: DW] = {16'h0, 8'(c), d};
      s_tid[c*IW +: IW]   = d[2:0] ^ 3'(c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string name, input logic [1:0] ch, input logic [15:0] d, input logic l);
    chk({name, " m_tvalid"}, 32'(m_tvalid), 32'd1);
    chk({name, " m_tchan"},  32'(m_tchan),  32'(ch));
    chk({name, " m_tdata"},  m_tdata,       {16'h0, d});
    chk({name, " m_tid"},    32'(m_tid),    32'(d[2:0] ^ {1'b0, ch}));
    chk({name, " m_tlast"},  32'(m_tlast),  32'(l));
  endtask

  initial begin
    // rst vld last dat rdy | e_vld e_chan e_dat e_last e_srdy e_cnt0 e_cnt1
    // reset, then first cycle after rst falls
    vq.push_back(vec_t'{1'b1, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 3'd0, 3'd0});
    vq.push_back(vec_t'{1'b1, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 3'd0, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 3'd0, 3'd0});
    // single beat on ch1
    vq.push_back(vec_t'{1'b0, 4'h2, 4'h2, 8'hA5, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 3'd0, 3'd1});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b1, 2'd1, 16'h01A5, 1'b1, 4'hF, 3'd0, 3'd1});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 3'd0, 3'd0});
    // ch0 4-beat and ch1 2-beat packets start together; ch0 wins (rr_ptr=2), ch1 follows
    vq.push_back(vec_t'{1'b0, 4'h3, 4'h0, 8'h10, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 3'd1, 3'd1});
    vq.push_back(vec_t'{1'b0, 4'h3, 4'h2, 8'h11, 1'b1, 1'b1, 2'd0, 16'h0010, 1'b0, 4'hF, 3'd2, 3'd2});
    vq.push_back(vec_t'{1'b0, 4'h1, 4'h0, 8'h12, 1'b1, 1'b1, 2'd0, 16'h0011, 1'b0, 4'hF, 3'd2, 3'd2});
    vq.push_back(vec_t'{1'b0, 4'h1, 4'h1, 8'h13, 1'b1, 1'b1, 2'd0, 16'h0012, 1'b0, 4'hF, 3'd2, 3'd2});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b1, 2'd0, 16'h0013, 1'b1, 4'hF, 3'd1, 3'd2});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 3'd0, 3'd2});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b1, 2'd1, 16'h0110, 1'b0, 4'hF, 3'd0, 3'd2});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b1, 2'd1, 16'h0111, 1'b1, 4'hF, 3'd0, 3'd1});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 3'd0, 3'd0});
    // backpressure: 6-beat packet on ch0 against a stalled link, FIFO fills at 4
    vq.push_back(vec_t'{1'b0, 4'h1, 4'h0, 8'h50, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 3'd1, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h1, 4'h0, 8'h51, 1'b0, 1'b1, 2'd0, 16'h0050, 1'b0, 4'hF, 3'd2, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h1, 4'h0, 8'h52, 1'b0, 1'b1, 2'd0, 16'h0050, 1'b0, 4'hF, 3'd3, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h1, 4'h0, 8'h53, 1'b0, 1'b1, 2'd0, 16'h0050, 1'b0, 4'hE, 3'd4, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h1, 4'h0, 8'h54, 1'b0, 1'b1, 2'd0, 16'h0050, 1'b0, 4'hE, 3'd4, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h1, 4'h0, 8'h54, 1'b1, 1'b1, 2'd0, 16'h0051, 1'b0, 4'hF, 3'd3, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h1, 4'h0, 8'h54, 1'b1, 1'b1, 2'd0, 16'h0052, 1'b0, 4'hF, 3'd3, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h1, 4'h1, 8'h55, 1'b1, 1'b1, 2'd0, 16'h0053, 1'b0, 4'hF, 3'd3, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b1, 2'd0, 16'h0054, 1'b0, 4'hF, 3'd2, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b1, 2'd0, 16'h0055, 1'b1, 4'hF, 3'd1, 3'd0});
    vq.push_back(vec_t'{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 3'd0, 3'd0});

    rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tid = '0; m_tready = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      string nm;
      v  = vq[i];
      nm = $sformatf("vec%0d", i);
      step(v.rst, v.vld, v.last, v.dat, v.rdy);
      chk({nm, " m_tvalid"}, 32'(m_tvalid), 32'(v.e_vld));
      chk({nm, " s_tready"}, 32'(s_tready), 32'(v.e_srdy));
      chk({nm, " cnt0"},     32'(fifo_count[2:0]), 32'(v.e_cnt0));
      chk({nm, " cnt1"},     32'(fifo_count[5:3]), 32'(v.e_cnt1));
      if (v.e_vld) chk_beat(nm, v.e_chan, v.e_dat, v.e_last);
      if (v.rst) begin
        chk({nm, " rst m_tchan"}, 32'(m_tchan), 32'd0);
        chk({nm, " rst count"},   32'(fifo_count), 32'd0);
      end
    end

    // Starvation: ch0 holds the grant with only 2 of 3 beats; ch1 waits behind it.
    step(1'b0, 4'h1, 4'h0, 8'h60, 1'b1);
    chk("starve wr0 m_tvalid", 32'(m_tvalid), 32'd0);
    step(1'b0, 4'h1, 4'h0, 8'h61, 1'b1);
    chk_beat("starve b60", 2'd0, 16'h0060, 1'b0);
    step(1'b0, 4'h2, 4'h0, 8'h70, 1'b1);
    chk_beat("starve b61", 2'd0, 16'h0061, 1'b0);
    step(1'b0, 4'h2, 4'h2, 8'h71, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("starve gap%0d m_tvalid", k), 32'(m_tvalid), 32'd0);
      chk($sformatf("starve gap%0d cnt1", k), 32'(fifo_count[5:3]), 32'd2);
      if (k < 3) step(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
    end
    step(1'b0, 4'h1, 4'h1, 8'h62, 1'b1);
    chk_beat("starve b62", 2'd0, 16'h0062, 1'b1);
    step(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
    chk("starve bubble m_tvalid", 32'(m_tvalid), 32'd0);
    step(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
    chk_beat("starve b70", 2'd1, 16'h0170, 1'b0);
    step(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
    chk_beat("starve b71", 2'd1, 16'h0171, 1'b1);
    step(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
    chk("starve end m_tvalid", 32'(m_tvalid), 32'd0);

    // Reset mid-packet with beats buffered in ch0 and ch1.
    step(1'b0, 4'h3, 4'h0, 8'h80, 1'b0);
    step(1'b0, 4'h1, 4'h0, 8'h81, 1'b0);
    chk_beat("midrst pre", 2'd0, 16'h0080, 1'b0);
    step(1'b1, 4'h0, 4'h0, 8'h00, 1'b1);
    chk("midrst m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst m_tchan", 32'(m_tchan), 32'd0);
    chk("midrst s_tready", 32'(s_tready), 32'hF);
    chk("midrst count", 32'(fifo_count), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
      chk($sformatf("postrst%0d m_tvalid", k), 32'(m_tvalid), 32'd0);
      chk($sformatf("postrst%0d count", k), 32'(fifo_count), 32'd0);
    end

    // Fairness: two 1-beat packets per channel, rr_ptr=0 after reset -> 0,1,2,3,0,1,2,3.
    step(1'b0, 4'hF, 4'hF, 8'h40, 1'b1);
    chk("fair load m_tvalid", 32'(m_tvalid), 32'd0);
    step(1'b0, 4'hF, 4'hF, 8'h41, 1'b1);
    chk_beat("fair k0", 2'd0, 16'h0040, 1'b1);
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
      chk($sformatf("fair bubble%0d m_tvalid", k), 32'(m_tvalid), 32'd0);
      step(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
      chk_beat($sformatf("fair k%0d", k), 2'(k % 4), {8'(k % 4), 8'h40 + 8'(k / 4)}, 1'b1);
    end
    step(1'b0, 4'h0, 4'h0, 8'h00, 1'b1);
    chk("fair end m_tvalid", 32'(m_tvalid), 32'd0);
    chk("fair end count", 32'(fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
